load_buffer: RTL and testbench
==============================

// Module: load_buffer
// PURPOSE
//  Downstream of the load/store queue's address unit: receives loads with the
//  effective address already computed, queues them in order, and issues them one
//  at a time to the memory controller.
//  Each returned datum is extended per load type and broadcast on the lbuffer CDB
//  (to ROB, RS, LSQueue). Drives lbuffer_rdy back to the LSQueue for flow control.
// PARAMETERS
//  DEPTH      8   queue entries; power of two, >= 4
//  PTR_WIDTH  3   log2(DEPTH)
// PORTS
//  clk_in              in   1            system clock
//  rst_in              in   1            reset; synchronous, active-high
//  rdy_in              in   1            global enable; when low all state holds
//  rob_flush_in        in   1            misprediction flush
//  au_en_in            in   1            load request valid (one-cycle pulse)
//  au_addr_in          in   32           effective address (vj + A)
//  au_dest_in          in   `ROB_WIDTH   ROB tag of the load
//  au_inst_type_in     in   `INST_TYPE_WIDTH  one of `LB,`LH,`LW,`LBU,`LHU
//  lbuffer_rdy_out     out  1            queue can take another request
//  mem_req_out         out  1            memory read request, level until done
//  mem_addr_out        out  32           read address
//  mem_len_out         out  2            0=byte, 1=half, 3=word
//  mem_done_in         in   1            one-cycle pulse: mem_data_in valid
//  mem_data_in         in   32           read data, LSB-aligned
//  cdb_en_out          out  1            broadcast valid (one-cycle pulse)
//  cdb_dest_out        out  `ROB_WIDTH   ROB tag
//  cdb_value_out       out  32           extended load value
// BEHAVIOUR
//  Reset/flush: head=tail=count=0, state IDLE; mem_req_out, cdb_en_out = 0;
//   mem_addr_out, mem_len_out, cdb_dest_out, cdb_value_out = 0 (reset only).
//  Enqueue: au_en_in with count<DEPTH writes the entry at tail; tail wraps mod DEPTH.
//   au_en_in while full is a protocol error; the request is dropped.
//  lbuffer_rdy_out = (count <= DEPTH-2), combinational. This leaves one slot of
//   slack because the upstream request is registered one cycle after rdy is sampled.
//  FSM:
//   IDLE: if count>0, present the head entry (addr, len from type), set
//    mem_req_out=1, go to WAIT. The request registers next cycle; the entry stays
//    in the queue.
//   WAIT: hold mem_req_out and mem_addr_out. On mem_done_in: mem_req_out=0, pop
//    the head, set cdb_en_out=1 next cycle with dest/value, go to IDLE.
//    Minimum 1 idle cycle between requests.
//   DRAIN: entered from WAIT on flush. mem_req_out stays 1 until mem_done_in
//    (the controller cannot abort). The datum is discarded with no CDB pulse,
//    then go to IDLE.
//   A flush in IDLE or DRAIN goes directly to IDLE or stays in DRAIN.
//  Extension: LB = sign-extend [7:0]; LBU = zero-extend [7:0]; LH = sign-extend
//   [15:0]; LHU = zero-extend [15:0]; LW = [31:0].
//  cdb_en_out is a one-cycle pulse. It is cleared every cycle by default and forced
//   to 0 on flush, even if the same cycle as mem_done_in.
//  Simultaneous enqueue+pop: count unchanged; both pointers advance.
//  Enqueue during DRAIN is accepted (post-flush loads) and issued after drain.
//  rdy_in low: no state or output changes; pulses on mem_done_in/au_en_in are not
//   captured (the system guarantees none occur).
// TESTING
//  1. Reset, then LW addr 0x100 tag 5; mem returns 0xDEADBEEF 3 cycles later
//     -> mem_len=3, single cdb pulse dest=5 value=0xDEADBEEF.
//  2. LB, then LBU, from data 0x000000F0 -> values 0xFFFFFFF0 then 0x000000F0;
//     LH/LHU on 0x00008001 -> 0xFFFF8001 / 0x00008001.
//  3. Enqueue DEPTH-1 back-to-back with memory stalled -> lbuffer_rdy_out low at
//     count=7; 8th pulse fills; all 8 broadcast in FIFO order; tags 0..7 across
//     pointer wrap.
//  4. Flush while WAIT, mem_done 4 cycles later with 0x1234 -> no cdb pulse,
//     mem_req stays high until done, queue empty.
//  5. Flush the same cycle as mem_done -> no cdb pulse. A new load enqueued the
//     cycle after the flush issues normally.
//  6. rdy_in low 5 cycles mid-WAIT -> outputs frozen, completion resumes normally.

Source files
------------

// File: rtl/load_buffer.sv
// In-order load queue: accepts address-resolved loads, issues them one at a time
// to the memory controller and broadcasts the extended result on the lbuffer CDB.

`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`endif
`ifndef LB
`define LB  3'd0
`endif
`ifndef LH
`define LH  3'd1
`endif
`ifndef LW
`define LW  3'd2
`endif
`ifndef LBU
`define LBU 3'd3
`endif
`ifndef LHU
`define LHU 3'd4
`endif

module load_buffer #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        rob_flush_in,
    input  logic                        au_en_in,
    input  logic [31:0]                 au_addr_in,
    input  logic [`ROB_WIDTH-1:0]       au_dest_in,
    input  logic [`INST_TYPE_WIDTH-1:0] au_inst_type_in,
    output logic                        lbuffer_rdy_out,
    output logic                        mem_req_out,
    output logic [31:0]                 mem_addr_out,
    output logic [1:0]                  mem_len_out,
    input  logic                        mem_done_in,
    input  logic [31:0]                 mem_data_in,
    output logic                        cdb_en_out,
    output logic [`ROB_WIDTH-1:0]       cdb_dest_out,
    output logic [31:0]                 cdb_value_out
);

    localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] RDY_MAX  = (PTR_WIDTH+1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic logic [1:0] len_of(input logic [`INST_TYPE_WIDTH-1:0] t);
        case (t)
            `LB, `LBU: len_of = 2'd0;
            `LH, `LHU: len_of = 2'd1;
            default:   len_of = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [`INST_TYPE_WIDTH-1:0] t,
                                           input logic [31:0] d);
        case (t)
            `LB:     extend = {{24{d[7]}}, d[7:0]};
            `LBU:    extend = {24'd0, d[7:0]};
            `LH:     extend = {{16{d[15]}}, d[15:0]};
            `LHU:    extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    logic [31:0]                 addr_mem_q [DEPTH];
    logic [`ROB_WIDTH-1:0]       dest_mem_q [DEPTH];
    logic [`INST_TYPE_WIDTH-1:0] type_mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [PTR_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [1:0]            mem_len_q, mem_len_d;
    logic                  cdb_en_q, cdb_en_d;
    logic [`ROB_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
    logic [31:0]           cdb_value_q, cdb_value_d;
    logic                  push_s, pop_s;

    // One slot of slack: upstream registers its request a cycle after sampling rdy.
    assign lbuffer_rdy_out = (count_q <= RDY_MAX);
    assign mem_req_out     = mem_req_q;
    assign mem_addr_out    = mem_addr_q;
    assign mem_len_out     = mem_len_q;
    assign cdb_en_out      = cdb_en_q;
    assign cdb_dest_out    = cdb_dest_q;
    assign cdb_value_out   = cdb_value_q;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush while a read is outstanding must drain it first.
    always_comb begin
        state_d = state_q;
        if (!rdy_in) begin
            state_d = state_q;
        end else if (rob_flush_in) begin
            case (state_q)
                S_WAIT, S_DRAIN: state_d = mem_done_in ? S_IDLE : S_DRAIN;
                default:         state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_d = S_WAIT;
                    else               state_d = S_IDLE;
                end
                S_WAIT, S_DRAIN: begin
                    if (mem_done_in) state_d = S_IDLE;
                    else             state_d = state_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and queue-pointer logic.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        cdb_en_d    = 1'b0;
        cdb_dest_d  = cdb_dest_q;
        cdb_value_d = cdb_value_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!rdy_in) begin
            cdb_en_d = cdb_en_q;
        end else if (rob_flush_in) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            mem_req_d = (state_q != S_IDLE) && !mem_done_in;
        end else begin
            push_s = au_en_in && (count_q != FULL_CNT);
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_mem_q[head_q];
                        mem_len_d  = len_of(type_mem_q[head_q]);
                    end else begin
                        mem_req_d = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_done_in) begin
                        mem_req_d   = 1'b0;
                        pop_s       = 1'b1;
                        cdb_en_d    = 1'b1;
                        cdb_dest_d  = dest_mem_q[head_q];
                        cdb_value_d = extend(type_mem_q[head_q], mem_data_in);
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem_done_in) mem_req_d = 1'b0;
                    else             mem_req_d = 1'b1;
                end
                default: mem_req_d = 1'b0;
            endcase
            if (push_s) tail_d = tail_q + 1'b1;
            else        tail_d = tail_q;
            if (pop_s)  head_d = head_q + 1'b1;
            else        head_d = head_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_len_q   <= 2'd0;
            cdb_en_q    <= 1'b0;
            cdb_dest_q  <= '0;
            cdb_value_q <= 32'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            cdb_en_q    <= cdb_en_d;
            cdb_dest_q  <= cdb_dest_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            addr_mem_q[tail_q] <= au_addr_in;
            dest_mem_q[tail_q] <= au_dest_in;
            type_mem_q[tail_q] <= au_inst_type_in;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: table of single loads, then FIFO fill/wrap,
// flush and stall sequences.

module tb_load_buffer;

    localparam logic [2:0] T_LB  = 3'd0;
    localparam logic [2:0] T_LH  = 3'd1;
    localparam logic [2:0] T_LW  = 3'd2;
    localparam logic [2:0] T_LBU = 3'd3;
    localparam logic [2:0] T_LHU = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        au_en = 1'b0;
    logic [31:0] au_addr = 32'd0;
    logic [3:0]  au_dest = 4'd0;
    logic [2:0]  au_type = 3'd0;
    logic        lb_rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        cdb_en;
    logic [3:0]  cdb_dest;
    logic [31:0] cdb_value;

    int n_cmp = 0;
    int n_err = 0;
    int cdb_cnt = 0;

    load_buffer #(.DEPTH(8), .PTR_WIDTH(3)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_flush_in(flush),
        .au_en_in(au_en), .au_addr_in(au_addr), .au_dest_in(au_dest),
        .au_inst_type_in(au_type), .lbuffer_rdy_out(lb_rdy),
        .mem_req_out(mem_req), .mem_addr_out(mem_addr), .mem_len_out(mem_len),
        .mem_done_in(mem_done), .mem_data_in(mem_data),
        .cdb_en_out(cdb_en), .cdb_dest_out(cdb_dest), .cdb_value_out(cdb_value)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cdb_en) cdb_cnt++;
    end

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [3:0]  dest;
        logic [31:0] data;
        logic [1:0]  exp_len;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] t, input logic [31:0] a, input logic [3:0] d);
        au_en = 1'b1; au_type = t; au_addr = a; au_dest = d;
        tick();
        au_en = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        chk("req_timeout", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic done(input logic [31:0] d);
        mem_done = 1'b1; mem_data = d;
        tick();
        mem_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{T_LW,  32'h100, 4'd5, 32'hDEADBEEF, 2'd3, 32'hDEADBEEF};
        vecs[1] = '{T_LB,  32'h104, 4'd1, 32'h000000F0, 2'd0, 32'hFFFFFFF0};
        vecs[2] = '{T_LBU, 32'h105, 4'd2, 32'h000000F0, 2'd0, 32'h000000F0};
        vecs[3] = '{T_LH,  32'h106, 4'd3, 32'h00008001, 2'd1, 32'hFFFF8001};
        vecs[4] = '{T_LHU, 32'h108, 4'd4, 32'h00008001, 2'd1, 32'h00008001};
        vecs[5] = '{T_LB,  32'h10C, 4'd6, 32'h1234567F, 2'd0, 32'h0000007F};
        vecs[6] = '{T_LHU, 32'h110, 4'd7, 32'hFFFFFFFF, 2'd1, 32'h0000FFFF};

        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_cdb", {31'd0, cdb_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_value", cdb_value, 32'd0);
        chk("rst_rdy", {31'd0, lb_rdy}, 32'd1);

        // Single loads with 3-cycle memory latency.
        for (int v = 0; v < 7; v++) begin
            enq(vecs[v].typ, vecs[v].addr, vecs[v].dest);
            wait_req();
            chk("vec_addr", mem_addr, vecs[v].addr);
            chk("vec_len", {30'd0, mem_len}, {30'd0, vecs[v].exp_len});
            repeat (2) tick();
            chk("vec_req_hold", {31'd0, mem_req}, 32'd1);
            chk("vec_nocdb", {31'd0, cdb_en}, 32'd0);
            done(vecs[v].data);
            chk("vec_cdb_en", {31'd0, cdb_en}, 32'd1);
            chk("vec_dest", {28'd0, cdb_dest}, {28'd0, vecs[v].dest});
            chk("vec_value", cdb_value, vecs[v].exp_val);
            chk("vec_req_drop", {31'd0, mem_req}, 32'd0);
            tick();
            chk("vec_pulse", {31'd0, cdb_en}, 32'd0);
        end

        // Fill with memory stalled; pointers start at 7 so tags wrap.
        for (int i = 0; i < 8; i++) begin
            au_en = 1'b1; au_type = T_LW; au_addr = 32'h400 + 32'(4 * i); au_dest = 4'(i);
            tick();
            chk("fill_rdy", {31'd0, lb_rdy}, (i + 1 <= 6) ? 32'd1 : 32'd0);
        end
        au_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_req();
            chk("fifo_addr", mem_addr, 32'h400 + 32'(4 * i));
            done(32'hA0 + 32'(i));
            chk("fifo_cdb_en", {31'd0, cdb_en}, 32'd1);
            chk("fifo_dest", {28'd0, cdb_dest}, 32'(i));
            chk("fifo_value", cdb_value, 32'hA0 + 32'(i));
        end
        tick();
        chk("fifo_rdy", {31'd0, lb_rdy}, 32'd1);

        // Flush while waiting: request must persist until the controller finishes.
        enq(T_LW, 32'h200, 4'd9);
        wait_req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", {31'd0, mem_req}, 32'd1);
            chk("drain_nocdb", {31'd0, cdb_en}, 32'd0);
            tick();
        end
        done(32'h1234);
        chk("drain_req_drop", {31'd0, mem_req}, 32'd0);
        chk("drain_nocdb2", {31'd0, cdb_en}, 32'd0);
        repeat (2) tick();
        chk("drain_empty", {31'd0, mem_req}, 32'd0);
        chk("drain_nocdb3", {31'd0, cdb_en}, 32'd0);

        // Flush coinciding with mem_done, then a fresh load right after.
        enq(T_LW, 32'h280, 4'd3);
        wait_req();
        flush = 1'b1; mem_done = 1'b1; mem_data = 32'h55555555;
        tick();
        flush = 1'b0; mem_done = 1'b0;
        chk("fd_nocdb", {31'd0, cdb_en}, 32'd0);
        chk("fd_req", {31'd0, mem_req}, 32'd0);
        enq(T_LH, 32'h300, 4'd4);
        chk("fd_nocdb2", {31'd0, cdb_en}, 32'd0);
        wait_req();
        chk("fd_addr", mem_addr, 32'h300);
        chk("fd_len", {30'd0, mem_len}, 32'd1);
        done(32'h00008001);
        chk("fd_cdb_en", {31'd0, cdb_en}, 32'd1);
        chk("fd_dest", {28'd0, cdb_dest}, 32'd4);
        chk("fd_value", cdb_value, 32'hFFFF8001);
        tick();

        // Global stall mid-wait.
        enq(T_LBU, 32'h500, 4'd11);
        wait_req();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'h500);
            chk("stall_nocdb", {31'd0, cdb_en}, 32'd0);
        end
        rdy = 1'b1;
        tick();
        done(32'h000000FF);
        chk("stall_cdb_en", {31'd0, cdb_en}, 32'd1);
        chk("stall_dest", {28'd0, cdb_dest}, 32'd11);
        chk("stall_value", cdb_value, 32'h000000FF);
        repeat (2) tick();

        chk("cdb_total", 32'(cdb_cnt), 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
